// File: rtl/cacheline_burst_adaptor_pkg.sv
// Shared types and constants for the cacheline burst adaptor.
// A 256-bit line moves as four 64-bit beats. Beat 0 is line bits [63:0].
// Line addresses are aligned to S_OFFSET bits.
package cacheline_burst_adaptor_pkg;

   localparam int S_OFFSET  = 5;
   localparam int S_LINE    = 256;
   localparam int S_BURST   = 64;
   localparam int NUM_BEATS = S_LINE / S_BURST;
   localparam int CNT_W     = $clog2(NUM_BEATS);

   typedef logic [S_LINE-1:0]  line_t;
   typedef logic [S_BURST-1:0] beat_t;
   typedef logic [31:0]        addr_t;
   typedef logic [CNT_W-1:0]   cnt_t;

   typedef enum logic [1:0] {
      IDLE,
      RD_BURST,
      WR_BURST,
      DONE
   } adaptor_state_e;

   // Clear the line-offset bits of a byte address.
   function automatic addr_t align_line(input addr_t a);
      return {a[31:S_OFFSET], {S_OFFSET{1'b0}}};
   endfunction

endpackage

// File: rtl/cacheline_burst_adaptor.sv
// cacheline_burst_adaptor
// This is the memory-side responder for the L1 cacheline interface. It serves one
// 256-bit fill or writeback per transaction as four 64-bit memory beats.
// When the transaction is complete it raises resp_o for a single cycle.
//
// Ports
//   clk        clock, all state updates on posedge
//   rst_n      synchronous active-low reset
//   line_i     writeback line from the cache (valid while write_i)
//   line_o     most recently filled line (valid while resp_o)
//   address_i  line address from the cache
//   read_i     cache fill request, held until resp_o
//   write_i    cache writeback request, held until resp_o
//   resp_o     one-cycle completion pulse to the cache
//   burst_i    read beat from memory, sampled when resp_i
//   burst_o    write beat to memory, zero outside a write burst
//   address_o  aligned line address, latched at accept
//   read_o     memory burst read, high for the whole read burst
//   write_o    memory burst write, high for the whole write burst
//   resp_i     memory beat strobe, one beat per high cycle
module cacheline_burst_adaptor
   import cacheline_burst_adaptor_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  line_t line_i,
   output line_t line_o,
   input  addr_t address_i,
   input  logic  read_i,
   input  logic  write_i,
   output logic  resp_o,
   input  beat_t burst_i,
   output beat_t burst_o,
   output addr_t address_o,
   output logic  read_o,
   output logic  write_o,
   input  logic  resp_i
);

   adaptor_state_e state;
   cnt_t           cnt;
   // Fills and writebacks use separate buffers.
   // This keeps a writeback from disturbing the last filled line seen on line_o.
   line_t          rd_buf;
   line_t          wr_buf;

   logic last_beat;
   assign last_beat = (cnt == cnt_t'(NUM_BEATS - 1));

   assign line_o = rd_buf;

   always_comb begin
      burst_o = '0;
      if (state == WR_BURST)
         burst_o = wr_buf[cnt*S_BURST +: S_BURST];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         rd_buf    <= '0;
         wr_buf    <= '0;
         address_o <= '0;
         read_o    <= 1'b0;
         write_o   <= 1'b0;
         resp_o    <= 1'b0;
      end else begin
         resp_o <= 1'b0;
         unique case (state)
            IDLE: begin
               // When both requests are present, the writeback is served first.
               if (write_i) begin
                  wr_buf    <= line_i;
                  address_o <= align_line(address_i);
                  cnt       <= '0;
                  write_o   <= 1'b1;
                  state     <= WR_BURST;
               end else if (read_i) begin
                  address_o <= align_line(address_i);
                  cnt       <= '0;
                  read_o    <= 1'b1;
                  state     <= RD_BURST;
               end
            end
            RD_BURST: begin
               if (resp_i) begin
                  rd_buf[cnt*S_BURST +: S_BURST] <= burst_i;
                  cnt <= cnt + cnt_t'(1);
                  if (last_beat) begin
                     read_o <= 1'b0;
                     resp_o <= 1'b1;
                     state  <= DONE;
                  end
               end
            end
            WR_BURST: begin
               if (resp_i) begin
                  cnt <= cnt + cnt_t'(1);
                  if (last_beat) begin
                     write_o <= 1'b0;
                     resp_o  <= 1'b1;
                     state   <= DONE;
                  end
               end
            end
            DONE: begin
               // The cache still holds its request during this cycle.
               // The request is not sampled here.
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed bench for cacheline_burst_adaptor. A transaction-level reference tracks what the
// outputs must be each cycle. Directed tasks drive the cache and memory sides and pin
// hand-computed literals.
`timescale 1ns/1ps
module tb_cacheline_burst_adaptor;
   import cacheline_burst_adaptor_pkg::*;

   logic  clk = 1'b0;
   logic  rst_n = 1'b0;
   line_t line_i = '0;
   line_t line_o;
   addr_t address_i = '0;
   logic  read_i = 1'b0;
   logic  write_i = 1'b0;
   logic  resp_o;
   beat_t burst_i = '0;
   beat_t burst_o;
   addr_t address_o;
   logic  read_o;
   logic  write_o;
   logic  resp_i = 1'b0;

   always #5 clk = ~clk;

   cacheline_burst_adaptor dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .line_i    (line_i),
      .line_o    (line_o),
      .address_i (address_i),
      .read_i    (read_i),
      .write_i   (write_i),
      .resp_o    (resp_o),
      .burst_i   (burst_i),
      .burst_o   (burst_o),
      .address_o (address_o),
      .read_o    (read_o),
      .write_o   (write_o),
      .resp_i    (resp_i)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: phase 0 = waiting for a request, 1 = moving beats, 2 = completion cycle.
   // kind 1 = fill, 2 = writeback. beats = beats moved so far in this transaction.
   int           phase = 0;
   int           kind = 0;
   int           beats = 0;
   logic [255:0] m_wline = '0;
   logic [255:0] m_fill = '0;
   logic [255:0] m_line = '0;
   logic [31:0]  m_addr = '0;
   bit           armed = 1'b0;
   int           resp_cnt = 0;

   always @(negedge clk) begin
      if (armed) begin
         check("read_o", read_o, (phase == 1 && kind == 1));
         check("write_o", write_o, (phase == 1 && kind == 2));
         check("resp_o", resp_o, (phase == 2));
         check("burst_o", burst_o, (phase == 1 && kind == 2) ? m_wline[beats*64 +: 64] : 64'h0);
         check("address_o", address_o, m_addr);
         if (!(phase == 1 && kind == 1))
            check("line_o", line_o, m_line);
         if (resp_o === 1'b1)
            resp_cnt++;
      end
      // Advance the reference using the inputs the next rising edge will sample.
      if (!rst_n) begin
         phase = 0; kind = 0; beats = 0;
         m_line = '0; m_addr = '0; m_fill = '0;
         armed = 1'b1;
      end else if (phase == 0) begin
         if (write_i) begin
            kind = 2; phase = 1; beats = 0;
            m_wline = line_i; m_addr = address_i & ~32'h1F;
         end else if (read_i) begin
            kind = 1; phase = 1; beats = 0;
            m_addr = address_i & ~32'h1F;
         end
      end else if (phase == 1) begin
         if (resp_i) begin
            if (kind == 1) m_fill[beats*64 +: 64] = burst_i;
            beats++;
            if (beats == 4) begin
               phase = 2;
               if (kind == 1) m_line = m_fill;
            end
         end
      end else begin
         phase = 0;
      end
   end

   logic [63:0] wb_seen [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_fill(input logic [31:0] a, input logic [255:0] d, input logic [15:0] pat,
                          input int plen, input int wait0);
      int k = 0;
      read_i = 1'b1; address_i = a;
      tick();
      repeat (wait0) tick();
      for (int i = 0; i < plen; i++) begin
         resp_i  = pat[i];
         burst_i = pat[i] ? d[k*64 +: 64] : 64'hDEAD_BEEF_0BAD_F00D;
         if (pat[i]) k++;
         tick();
      end
      resp_i = 1'b0; burst_i = '0;
      @(negedge clk);
      check("fill resp_o", resp_o, 1'b1);
      check("fill line_o", line_o, d);
      tick();
      read_i = 1'b0; address_i = '0;
   endtask

   task automatic do_wb(input logic [31:0] a, input logic [255:0] d, input logic [15:0] pat,
                        input int plen);
      int k = 0;
      write_i = 1'b1; line_i = d; address_i = a;
      tick();
      for (int i = 0; i < plen; i++) begin
         resp_i = pat[i];
         if (pat[i]) begin
            wb_seen[k] = burst_o;
            check("wb write_o", write_o, 1'b1);
            k++;
         end
         tick();
      end
      resp_i = 1'b0;
      @(negedge clk);
      check("wb resp_o", resp_o, 1'b1);
      check("wb write_o done", write_o, 1'b0);
      tick();
      write_i = 1'b0; read_i = 1'b0; line_i = '0; address_i = '0;
   endtask

   localparam logic [255:0] FILL1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
   localparam logic [255:0] FILL3 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                     64'hA5A5_A5A5_5A5A_5A5A, 64'h0F0F_0F0F_F0F0_F0F0};
   localparam logic [255:0] WB2   = {64'hD, 64'hC, 64'hB, 64'hA};

   initial begin
      int r0;
      repeat (3) tick();
      @(negedge clk);
      check("reset resp_o", resp_o, 1'b0);
      check("reset read_o", read_o, 1'b0);
      check("reset line_o", line_o, 256'h0);
      check("reset address_o", address_o, 32'h0);
      tick();
      rst_n = 1'b1;
      tick();

      // 1: fill with a 3-cycle memory wait
      do_fill(32'h0000_1234, FILL1, 16'h000F, 4, 3);
      @(negedge clk);
      check("t1 address_o", address_o, 32'h0000_1220);
      check("t1 line_o", line_o, FILL1);
      tick();

      // resp_i while idle must be ignored
      resp_i = 1'b1; tick(); resp_i = 1'b0; tick();

      // 2: writeback beat order
      do_wb(32'h0000_2040, WB2, 16'h000F, 4);
      check("t2 beat0", wb_seen[0], 64'hA);
      check("t2 beat1", wb_seen[1], 64'hB);
      check("t2 beat2", wb_seen[2], 64'hC);
      check("t2 beat3", wb_seen[3], 64'hD);
      @(negedge clk);
      check("t2 line_o kept", line_o, FILL1);
      tick();

      // 3: fill with beat gaps 1,0,0,1,0,1,1
      do_fill(32'h0000_3FFF, FILL3, 16'h0069, 7, 0);
      @(negedge clk);
      check("t3 address_o", address_o, 32'h0000_3FE0);
      tick();

      // 4: both requests, writeback wins
      r0 = resp_cnt;
      read_i = 1'b1;
      do_wb(32'h0000_4000, {64'h4D, 64'h4C, 64'h4B, 64'h4A}, 16'h000F, 4);
      tick();
      check("t4 resp count", resp_cnt - r0, 1);
      check("t4 beat0", wb_seen[0], 64'h4A);

      // 5: reset after two fill beats
      read_i = 1'b1; address_i = 32'h0000_5008;
      tick();
      resp_i = 1'b1; burst_i = 64'h5555_5555_5555_5555; tick();
      burst_i = 64'h6666_6666_6666_6666; tick();
      resp_i = 1'b0; burst_i = '0; read_i = 1'b0; rst_n = 1'b0;
      tick();
      @(negedge clk);
      check("t5 read_o", read_o, 1'b0);
      check("t5 resp_o", resp_o, 1'b0);
      check("t5 line_o", line_o, 256'h0);
      tick();
      rst_n = 1'b1;
      tick();
      do_fill(32'h0000_6010, FILL3, 16'h000F, 4, 1);

      // 6: back-to-back fill then writeback from the IDLE cycle
      do_fill(32'h0000_7000, FILL1, 16'h000F, 4, 0);
      do_wb(32'h0000_8000, WB2, 16'h000F, 4);
      @(negedge clk);
      check("t6 line_o kept", line_o, FILL1);
      check("t6 address_o", address_o, 32'h0000_8000);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (checks %0d, errors %0d)", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
